mc_conv_scale_pipe: RTL and testbench
=====================================

MC_CONV_SCALE_PIPE -- requirements
Module: mc_conv_scale_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed sample width.
REQ-002 Parameter COEF_WIDTH, default 16: signed coefficient and scale width.
REQ-003 Parameter ACC_WIDTH, default 48: convolution accumulator width.
REQ-004 Parameter KERNEL_SIZE, default 5: taps per channel, range 1..16.
REQ-005 Parameter NUM_CH, default 4: interleaved channels, range 1..64.
REQ-006 Parameter FRAC_BITS, default 14: fractional bits of coefficients and scales.
REQ-007 Parameter CONV_COEFFS [KERNEL_SIZE], default all 0: taps shared by all channels; index 0 multiplies the newest sample.
REQ-008 Parameter SCALE_INIT [NUM_CH], default all 1<<FRAC_BITS: per-channel scale reset values.
REQ-009 clk  in  1  single clock; all state updates on its rising edge.
REQ-010 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-011 clear  in  1  synchronous flush: zero histories and channel counter, empty pipeline.
REQ-012 bypass  in  1  1 = skip convolution; sample goes straight to the scale stage.
REQ-013 in_sample  in  DATA_WIDTH  signed input, channel-interleaved ch0..ch(NUM_CH-1).
REQ-014 in_valid / in_ready  in / out  1 each  input handshake; a sample is accepted when both are high.
REQ-015 cfg_we, cfg_ch, cfg_scale  in  1, clog2(NUM_CH), COEF_WIDTH  runtime scale write.
REQ-016 out_sample  out  DATA_WIDTH  signed result.
REQ-017 out_ch  out  clog2(NUM_CH)  channel of out_sample.
REQ-018 out_last  out  1  high with the channel NUM_CH-1 result.
REQ-019 out_valid / out_ready  out / in  1 each  output handshake.
REQ-020 sat_flag  out  1  sticky; set on any saturation.

Function
REQ-021 Input channel counter: increments per accepted sample, wraps NUM_CH-1 -> 0, tags each sample.
REQ-022 Each channel has its own KERNEL_SIZE-deep history, zero-filled initially; only that channel's accepted samples shift it.
REQ-023 Conv result = sum over k of hist[ch][k]*CONV_COEFFS[k] in ACC_WIDTH, with the current sample as hist[0].
REQ-024 Conv result is rounded (add 1<<(FRAC_BITS-1), arithmetic shift right FRAC_BITS) and saturated to DATA_WIDTH.
REQ-025 With bypass=1 the scale-stage input is the accepted sample; histories are still updated.
REQ-026 Scale result = stage input * scale[ch], rounded and saturated as in REQ-024.
REQ-027 Pipeline: 3 register stages (tap products, sum/round/sat, scale/round/sat); out_valid asserts 3 cycles after acceptance when not stalled.
REQ-028 Global stall when out_valid=1 and out_ready=0: every stage holds and outputs stay stable.
REQ-029 in_ready = !clear and !(out_valid and !out_ready); it is combinational.
REQ-030 One result per accepted sample, in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-031 Scale write: scale[cfg_ch] <= cfg_scale; it applies to samples entering the scale stage on the following cycle or later. A cfg_ch >= NUM_CH is ignored.
REQ-032 clear=1: the sample is not accepted, histories, counter and stage valids are zeroed next cycle, and out_valid is 0 the next cycle; scales and sat_flag are kept.
REQ-033 sat_flag is set by saturation in either stage; only rst_n clears it.
REQ-034 Saturation limits are +(2^(DATA_WIDTH-1)-1) and -2^(DATA_WIDTH-1).

Reset
REQ-035 rst_n low: immediately out_valid=0, out_sample=0, out_ch=0, out_last=0, sat_flag=0; histories and counter 0; scales set to SCALE_INIT.
REQ-036 Reset mid-stream discards all in-flight samples; after rst_n rises the first accepted sample is ch0.

Structure
REQ-037 Package mc_conv_pkg holds the default widths, the clog2-derived channel index type, and the round-and-saturate function used by both stages.
REQ-038 Sub-module ch_history holds the per-channel history register file: write-shift on accept, parallel read of KERNEL_SIZE taps for the addressed channel.

Verification
REQ-039 NUM_CH=2, K=3, coeffs {16384,0,0}, scales 16384; inputs 100,-200,300,-400 -> outputs identical, out_ch 0,1,0,1, out_last on ch1, latency 3.
REQ-040 Coeffs {16384,16384,16384}, ch0 inputs 30000 x3 -> ch0 outputs 30000, 32767, 32767; sat_flag=1 from the first saturation.
REQ-041 out_ready low 5 cycles mid-stream -> in_ready low, out_sample/out_ch stable, full sequence later delivered intact.
REQ-042 cfg write ch1=8192, then input 1000 on ch0 and ch1 with identity conv -> out 1000 (ch0) and 500 (ch1).
REQ-043 clear asserted with in_valid=1 after 3 samples -> sample not accepted, no further outputs, next accepted sample is ch0 with zero history.
REQ-044 rst_n pulse while 2 samples are in flight -> out_valid drops immediately, no stale output after release, scales back to SCALE_INIT.

Source files
------------

// File: rtl/mc_conv_pkg.sv
// Shared widths, channel index sizing and the round/saturate helper for the conv-scale pipe.
// Pure declarations: no latency. No flow control.
// The round/saturate helper works in 64 bits, so callers truncate its value field to their own width.
package mc_conv_pkg;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_COEF_WIDTH  = 16;
    localparam int DEF_ACC_WIDTH   = 48;
    localparam int DEF_KERNEL_SIZE = 5;
    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_FRAC_BITS   = 14;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CH_W = ch_width(DEF_NUM_CH);
    typedef logic [DEF_CH_W-1:0] ch_idx_t;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } rs_t;

    // Round half-up by 2^frac, then clamp to a signed dw-bit range.
    function automatic rs_t round_sat(input logic signed [63:0] v, input int frac, input int dw);
        rs_t                r;
        logic signed [63:0] t;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        t  = (frac > 0) ? ((v + (64'sd1 <<< (frac - 1))) >>> frac) : v;
        r.sat = 1'b0;
        r.val = t;
        if (t > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (t < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction
endpackage

// File: rtl/ch_history.sv
// Per-channel sample history; shifts the addressed channel on write, reads all taps in parallel.
// Read is combinational (tap 0 is the incoming sample); write lands on the next clock.
// No flow control: the parent only asserts wr_en for accepted samples.
module ch_history
    import mc_conv_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CH_W        = DEF_CH_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic                              wr_en,
    input  logic [CH_W-1:0]                   ch,
    input  logic [DATA_WIDTH-1:0]             din,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0] taps
);
    // Only the older KERNEL_SIZE-1 samples are stored; the newest tap is din itself.
    localparam int HD = (KERNEL_SIZE > 1) ? KERNEL_SIZE - 1 : 1;

    logic [DATA_WIDTH-1:0] hist [NUM_CH][HD];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < HD; k++)
                    hist[c][k] <= '0;
        end else if (clear) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < HD; k++)
                    hist[c][k] <= '0;
        end else if (wr_en && (KERNEL_SIZE > 1)) begin
            hist[ch][0] <= din;
            for (int k = 1; k < HD; k++)
                hist[ch][k] <= hist[ch][k-1];
        end
    end

    always_comb begin
        taps = '0;
        taps[DATA_WIDTH-1:0] = din;
        for (int k = 1; k < KERNEL_SIZE; k++)
            taps[k*DATA_WIDTH +: DATA_WIDTH] = hist[ch][k-1];
    end
endmodule

// File: rtl/mc_conv_scale_pipe.sv
// Channel-interleaved FIR convolution followed by per-channel scaling, both rounded and saturated.
// Latency 3 cycles: tap products, sum/round/sat, scale/round/sat.
// Whole pipe freezes while out_valid && !out_ready; in_ready drops combinationally.
module mc_conv_scale_pipe
    import mc_conv_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COEF_WIDTH  = DEF_COEF_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int FRAC_BITS   = DEF_FRAC_BITS,
    parameter logic signed [COEF_WIDTH-1:0] CONV_COEFFS [KERNEL_SIZE] = '{default: '0},
    parameter logic signed [COEF_WIDTH-1:0] SCALE_INIT [NUM_CH] = '{default: COEF_WIDTH'(1 << FRAC_BITS)},
    localparam int CH_W = ch_width(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  bypass,
    input  logic [DATA_WIDTH-1:0] in_sample,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [COEF_WIDTH-1:0] cfg_scale,
    output logic [DATA_WIDTH-1:0] out_sample,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat_flag
);
    localparam int PW = DATA_WIDTH + COEF_WIDTH;

    logic stall;
    logic accept;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~clear & ~stall;
    assign accept   = in_valid & in_ready;

    logic [CH_W-1:0]                   in_ch;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] taps;

    ch_history #(
        .DATA_WIDTH (DATA_WIDTH),
        .KERNEL_SIZE(KERNEL_SIZE),
        .NUM_CH     (NUM_CH),
        .CH_W       (CH_W)
    ) u_hist (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .wr_en(accept),
        .ch   (in_ch),
        .din  (in_sample),
        .taps (taps)
    );

    logic                         s1_vld;
    logic                         s1_byp;
    logic [CH_W-1:0]              s1_ch;
    logic signed [DATA_WIDTH-1:0] s1_smp;
    logic signed [ACC_WIDTH-1:0]  s1_prod [KERNEL_SIZE];
    logic                         s2_vld;
    logic [CH_W-1:0]              s2_ch;
    logic signed [DATA_WIDTH-1:0] s2_dat;
    logic signed [COEF_WIDTH-1:0] scale [NUM_CH];

    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [PW-1:0]         scaled;
    logic signed [DATA_WIDTH-1:0] s2_next;
    rs_t                          conv_rs;
    rs_t                          scale_rs;

    always_comb begin
        acc = '0;
        for (int k = 0; k < KERNEL_SIZE; k++)
            acc = acc + s1_prod[k];
        conv_rs  = round_sat(64'(acc), FRAC_BITS, DATA_WIDTH);
        s2_next  = s1_byp ? s1_smp : DATA_WIDTH'(conv_rs.val);
        scaled   = PW'(s2_dat) * PW'(scale[s2_ch]);
        scale_rs = round_sat(64'(scaled), FRAC_BITS, DATA_WIDTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ch      <= '0;
            s1_vld     <= 1'b0;
            s1_byp     <= 1'b0;
            s1_ch      <= '0;
            s1_smp     <= '0;
            for (int k = 0; k < KERNEL_SIZE; k++)
                s1_prod[k] <= '0;
            s2_vld     <= 1'b0;
            s2_ch      <= '0;
            s2_dat     <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_ch     <= '0;
            out_last   <= 1'b0;
            sat_flag   <= 1'b0;
        end else if (clear) begin
            in_ch     <= '0;
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            if (accept)
                in_ch <= (in_ch == CH_W'(NUM_CH - 1)) ? '0 : in_ch + 1'b1;
            s1_vld <= accept;
            s1_byp <= bypass;
            s1_ch  <= in_ch;
            s1_smp <= $signed(in_sample);
            for (int k = 0; k < KERNEL_SIZE; k++)
                s1_prod[k] <= ACC_WIDTH'($signed(taps[k*DATA_WIDTH +: DATA_WIDTH]))
                            * ACC_WIDTH'(CONV_COEFFS[k]);
            s2_vld     <= s1_vld;
            s2_ch      <= s1_ch;
            s2_dat     <= s2_next;
            out_valid  <= s2_vld;
            out_ch     <= s2_ch;
            out_last   <= (s2_ch == CH_W'(NUM_CH - 1));
            out_sample <= DATA_WIDTH'(scale_rs.val);
            // Bypassed samples never pass the conv clamp, so only real conv saturation counts.
            if ((s1_vld && !s1_byp && conv_rs.sat) || (s2_vld && scale_rs.sat))
                sat_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++)
                scale[c] <= SCALE_INIT[c];
        end else if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
            scale[cfg_ch] <= cfg_scale;
        end
    end
endmodule

// File: tb/tb_mc_conv_scale_pipe.sv
// Scoreboarded bench: dut_a has an identity kernel, dut_b sums the last three samples per channel.
module tb_mc_conv_scale_pipe;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int CH = 2;
    localparam int K  = 3;
    localparam int FB = 14;
    localparam logic signed [CW-1:0] COEF_A [K]  = '{16'sd16384, 16'sd0, 16'sd0};
    localparam logic signed [CW-1:0] COEF_B [K]  = '{16'sd16384, 16'sd16384, 16'sd16384};
    localparam logic signed [CW-1:0] SCL    [CH] = '{16'sd16384, 16'sd16384};

    typedef struct {
        int s;
        int ch;
        bit last;
        int cyc;
        bit lat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic a_clear = 0, a_bypass = 0, a_in_valid = 0, a_out_ready = 1, a_cfg_we = 0, a_cfg_ch = 0;
    logic [DW-1:0] a_in_sample = '0;
    logic [CW-1:0] a_cfg_scale = '0;
    logic a_in_ready, a_out_valid, a_out_last, a_sat_flag, a_out_ch;
    logic [DW-1:0] a_out_sample;

    logic b_clear = 0, b_bypass = 0, b_in_valid = 0, b_out_ready = 1, b_cfg_we = 0, b_cfg_ch = 0;
    logic [DW-1:0] b_in_sample = '0;
    logic [CW-1:0] b_cfg_scale = '0;
    logic b_in_ready, b_out_valid, b_out_last, b_sat_flag, b_out_ch;
    logic [DW-1:0] b_out_sample;

    mc_conv_scale_pipe #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .ACC_WIDTH(48), .KERNEL_SIZE(K),
        .NUM_CH(CH), .FRAC_BITS(FB), .CONV_COEFFS(COEF_A), .SCALE_INIT(SCL)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear), .bypass(a_bypass),
        .in_sample(a_in_sample), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .cfg_we(a_cfg_we), .cfg_ch(a_cfg_ch), .cfg_scale(a_cfg_scale),
        .out_sample(a_out_sample), .out_ch(a_out_ch), .out_last(a_out_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .sat_flag(a_sat_flag));

    mc_conv_scale_pipe #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .ACC_WIDTH(48), .KERNEL_SIZE(K),
        .NUM_CH(CH), .FRAC_BITS(FB), .CONV_COEFFS(COEF_B), .SCALE_INIT(SCL)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .bypass(b_bypass),
        .in_sample(b_in_sample), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch), .cfg_scale(b_cfg_scale),
        .out_sample(b_out_sample), .out_ch(b_out_ch), .out_last(b_out_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .sat_flag(b_sat_flag));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    bit lat_en = 0;
    exp_t qa[$];
    exp_t qb[$];
    int coef_m [2][K];
    int hist_m [2][CH][K];
    int scl_m  [2][CH];
    int chc_m  [2];

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int rsat(input longint v);
        longint t;
        t = (v + 64'sd8192) >>> FB;
        if (t > 32767) return 32767;
        if (t < -32768) return -32768;
        return int'(t);
    endfunction

    task automatic model_reset(input int d);
        chc_m[d] = 0;
        for (int c = 0; c < CH; c++) begin
            scl_m[d][c] = 16384;
            for (int k = 0; k < K; k++) hist_m[d][c][k] = 0;
        end
    endtask

    task automatic model_push(input int d, input int s, input bit byp);
        int ch;
        int cv;
        longint acc;
        exp_t e;
        ch = chc_m[d];
        for (int k = K - 1; k > 0; k--) hist_m[d][ch][k] = hist_m[d][ch][k-1];
        hist_m[d][ch][0] = s;
        acc = 0;
        for (int k = 0; k < K; k++) acc += longint'(hist_m[d][ch][k]) * coef_m[d][k];
        cv = byp ? s : rsat(acc);
        e.s    = rsat(longint'(cv) * scl_m[d][ch]);
        e.ch   = ch;
        e.last = (ch == CH - 1);
        e.cyc  = cyc + 3;
        e.lat  = lat_en;
        if (d == 0) qa.push_back(e);
        else qb.push_back(e);
        chc_m[d] = (ch + 1) % CH;
    endtask

    task automatic send(input int d, input int s);
        int  n = 0;
        bit  done = 0;
        if (d == 0) begin a_in_sample = DW'(s); a_in_valid = 1; end
        else begin b_in_sample = DW'(s); b_in_valid = 1; end
        while (!done) begin
            @(negedge clk);
            if ((d == 0) ? a_in_ready : b_in_ready) begin
                model_push(d, s, (d == 0) ? a_bypass : b_bypass);
                done = 1;
            end else if (++n > 100) begin
                check("send_timeout", n, 0);
                done = 1;
            end
        end
        @(posedge clk); #2;
        if (d == 0) a_in_valid = 0;
        else b_in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() + qb.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", qa.size() + qb.size(), 0);
        @(posedge clk); #2;
    endtask

    task automatic mon_a();
        exp_t e;
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) check("a_spurious", a_out_valid, 0);
            else begin
                e = qa.pop_front();
                check("a_sample", $signed(a_out_sample), e.s);
                check("a_ch", a_out_ch, e.ch);
                check("a_last", a_out_last, e.last);
                if (e.lat) check("a_latency", cyc, e.cyc);
            end
        end
    endtask

    task automatic mon_b();
        exp_t e;
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) check("b_spurious", b_out_valid, 0);
            else begin
                e = qb.pop_front();
                check("b_sample", $signed(b_out_sample), e.s);
                check("b_ch", b_out_ch, e.ch);
                check("b_last", b_out_last, e.last);
            end
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        mon_a();
        mon_b();
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < K; k++) begin
            coef_m[0][k] = COEF_A[k];
            coef_m[1][k] = COEF_B[k];
        end
        model_reset(0);
        model_reset(1);

        #1 rst_n = 0;
        #2;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_sample", a_out_sample, 0);
        check("rst_out_ch", a_out_ch, 0);
        check("rst_out_last", a_out_last, 0);
        check("rst_sat_flag", a_sat_flag, 0);
        check("rst_in_ready", a_in_ready, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #2;

        // Identity kernel, back-to-back, fixed latency.
        lat_en = 1;
        send(0, 100); send(0, -200); send(0, 300); send(0, -400);
        lat_en = 0;
        drain();

        // Output stall for five cycles mid-stream.
        send(0, 11); send(0, 22); send(0, 33);
        a_out_ready = 0;
        a_in_sample = DW'(44);
        a_in_valid  = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!a_out_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", a_in_ready, 0);
            check("stall_out_valid", a_out_valid, 1);
            check("stall_sample", $signed(a_out_sample), qa[0].s);
            check("stall_ch", a_out_ch, qa[0].ch);
            @(negedge clk);
        end
        @(posedge clk); #2;
        a_out_ready = 1;
        send(0, 44);
        drain();

        // Runtime scale write on channel 1.
        a_cfg_ch = 1; a_cfg_scale = 16'd8192; a_cfg_we = 1;
        @(posedge clk); #2;
        a_cfg_we = 0;
        scl_m[0][1] = 8192;
        send(0, 1000); send(0, 1000);
        drain();

        // Saturation on the three-tap sum.
        send(1, 30000); send(1, 0);
        drain();
        check("sat_before", b_sat_flag, 0);
        send(1, 30000); send(1, 0);
        drain();
        check("sat_after", b_sat_flag, 1);
        send(1, 30000); send(1, 0);
        drain();

        // Clear with a pending sample.
        send(1, 10); send(1, 20); send(1, 30);
        drain();
        b_clear = 1; b_in_sample = DW'(999); b_in_valid = 1;
        @(negedge clk);
        check("clear_in_ready", b_in_ready, 0);
        @(posedge clk); #2;
        b_clear = 0; b_in_valid = 0;
        chc_m[1] = 0;
        for (int c = 0; c < CH; c++) for (int k = 0; k < K; k++) hist_m[1][c][k] = 0;
        @(negedge clk);
        check("clear_out_valid", b_out_valid, 0);
        check("clear_sat_kept", b_sat_flag, 1);
        repeat (4) @(negedge clk);
        @(posedge clk); #2;
        send(1, 7); send(1, 100);
        b_bypass = 1;
        send(1, 40);
        b_bypass = 0;
        send(1, 1); send(1, 2);
        drain();

        // Reset with two samples in flight.
        a_out_ready = 0;
        send(0, 5); send(0, 6);
        n = 0;
        do begin @(negedge clk); n++; end while (!a_out_valid && n < 20);
        check("pre_rst_valid", a_out_valid, 1);
        #1 rst_n = 0;
        #1;
        check("mid_rst_out_valid", a_out_valid, 0);
        check("mid_rst_out_sample", a_out_sample, 0);
        check("mid_rst_out_ch", a_out_ch, 0);
        check("mid_rst_sat_flag", b_sat_flag, 0);
        qa.delete();
        qb.delete();
        model_reset(0);
        model_reset(1);
        @(posedge clk); #2;
        rst_n = 1;
        a_out_ready = 1;
        repeat (5) @(negedge clk);
        @(posedge clk); #2;
        send(0, 1000); send(0, 1000);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
